// File: rtl/ctl_sequencer.sv
// ctl_sequencer: fetch/decode/execute FSM driving every shared-bus enable, with memory wait states,
// interrupt enable, halt with wake-up and vectored interrupt entry.
module ctl_sequencer #(
  parameter int WIDTH = 16,
  parameter logic [2:0] LINK_REG = 3'd1,
  parameter logic [2:0] TMP_REG = 3'd7,
  parameter logic [15:0] IRQ_VECTOR = 16'h0010
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH-1:0] in,
  input  logic [3:0] flags,
  input  logic mem_ready,
  input  logic irq,
  output logic [3:0] alu_opcode,
  output logic alu_out_en,
  output logic alu_ar_flag,
  output logic mem_addr_en,
  output logic mem_in_en,
  output logic mem_out_en,
  output logic [2:0] reg_src_sel,
  output logic [2:0] reg_dst_sel,
  output logic reg_in_en,
  output logic reg_out_en,
  output logic reg_pc_inc,
  output logic ctl_out_en,
  output logic dsp_in_en,
  output logic [WIDTH-1:0] out,
  output logic irq_ack,
  output logic halted
);
  typedef enum logic [2:0] {FETCH_ADDR, FETCH_DATA, EXEC, HALT, INT_SAVE, INT_JUMP} state_t;
  state_t state, state_n;
  logic [1:0] e, e_n, fin;
  logic [15:0] inst;
  logic [3:0] op, sys;
  logic [2:0] dst, src;
  logic ie, ie_n, load, stall, take_irq, unused_hi;
  logic imm, ind, is_alu, is_sh, is_cmp, arith, a_imm, a_ind, br_go, ld_go;
  assign op = inst[15:12];
  assign sys = inst[11:8];
  assign dst = inst[11:9];
  assign imm = inst[8];
  assign ind = inst[7];
  assign src = inst[6:4];
  assign unused_hi = ^in;
  assign take_irq = ie & irq;
  assign is_alu = op >= 4'd3 && op <= 4'd9;
  assign is_sh = op == 4'd10 || op == 4'd11;
  assign is_cmp = op == 4'd14;
  assign arith = is_alu | is_sh | is_cmp;
  assign a_imm = (is_alu | is_cmp) & imm;
  assign a_ind = arith & !a_imm & ind;
  // a branch decided taken at e0 stays taken on its indirect step even if flags move
  assign br_go = op == 4'd15 && ((flags[2'd3 - dst[2:1]] ^ dst[0]) || e != 2'd0);
  assign ld_go = op == 4'd1 || br_go;
  assign fin = arith ? (a_imm ? 2'd1 : a_ind ? 2'd2 : 2'd0)
             : ld_go ? {1'b0, ind & !imm}
             : op == 4'd2 || op == 4'd13 ? 2'd1
             : op == 4'd0 && sys == 4'd2 ? {1'b0, ind} : 2'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_ADDR;
      e <= 2'd0;
      inst <= 16'h0;
      ie <= 1'b0;
    end else begin
      state <= state_n;
      e <= e_n;
      ie <= ie_n;
      if (load) inst <= in[15:0];
    end
  end
  always_comb begin
    alu_opcode = 4'd0;
    alu_out_en = 1'b0;
    alu_ar_flag = 1'b0;
    mem_addr_en = 1'b0;
    mem_in_en = 1'b0;
    mem_out_en = 1'b0;
    reg_src_sel = 3'd0;
    reg_dst_sel = 3'd0;
    reg_in_en = 1'b0;
    reg_out_en = 1'b0;
    reg_pc_inc = 1'b0;
    ctl_out_en = 1'b0;
    dsp_in_en = 1'b0;
    irq_ack = 1'b0;
    halted = 1'b0;
    state_n = state;
    e_n = 2'd0;
    ie_n = ie;
    load = 1'b0;
    stall = 1'b0;
    if (!rst) begin
      case (state)
        FETCH_ADDR: begin
          reg_out_en = !take_irq;
          mem_addr_en = !take_irq;
          state_n = take_irq ? INT_SAVE : FETCH_DATA;
        end
        FETCH_DATA: begin
          mem_out_en = 1'b1;
          reg_pc_inc = mem_ready;
          load = mem_ready;
          state_n = mem_ready ? EXEC : FETCH_DATA;
        end
        EXEC: begin
          if (arith) begin
            if (e == fin) begin
              alu_out_en = 1'b1;
              alu_opcode = is_cmp ? 4'd4 : op;
              alu_ar_flag = is_sh & imm;
              reg_src_sel = fin == 2'd0 ? src : TMP_REG;
              reg_dst_sel = dst;
              reg_in_en = !is_cmp;
            end else if (a_imm) begin
              ctl_out_en = 1'b1;
              reg_dst_sel = TMP_REG;
              reg_in_en = 1'b1;
            end else if (e == 2'd0) begin
              reg_src_sel = src;
              reg_out_en = 1'b1;
              mem_addr_en = 1'b1;
            end else begin
              mem_out_en = 1'b1;
              reg_dst_sel = TMP_REG;
              reg_in_en = 1'b1;
            end
          end else if (ld_go) begin
            reg_src_sel = imm || (ind && e != 2'd0) ? 3'd0 : src;
            reg_out_en = !imm && (!ind || e == 2'd0);
            mem_addr_en = !imm && ind && e == 2'd0;
            mem_out_en = !imm && ind && e != 2'd0;
            ctl_out_en = imm;
            reg_in_en = imm || !ind || e != 2'd0;
            reg_dst_sel = reg_in_en && op != 4'd15 ? dst : 3'd0;
          end else if (op == 4'd2) begin
            reg_src_sel = e == 2'd0 ? src : dst;
            reg_out_en = 1'b1;
            mem_addr_en = e == 2'd0;
            mem_in_en = e != 2'd0;
          end else if (op == 4'd12 || op == 4'd13) begin
            reg_out_en = op == 4'd13 && e == 2'd0;
            reg_dst_sel = reg_out_en ? LINK_REG : 3'd0;
            ctl_out_en = !reg_out_en;
            reg_in_en = 1'b1;
          end else if (op == 4'd0 && sys == 4'd2) begin
            reg_src_sel = e == 2'd0 ? src : 3'd0;
            reg_out_en = e == 2'd0;
            mem_addr_en = ind && e == 2'd0;
            mem_out_en = ind && e != 2'd0;
            dsp_in_en = !ind || e != 2'd0;
          end
          if (op == 4'd0) ie_n = sys == 4'd3 ? 1'b1 : sys == 4'd4 ? 1'b0 : ie;
          stall = (mem_out_en | mem_in_en) & !mem_ready;
          e_n = stall ? e : e == fin ? 2'd0 : e + 2'd1;
          state_n = stall || e != fin ? EXEC : op == 4'd0 && sys == 4'd15 ? HALT : FETCH_ADDR;
        end
        HALT: begin
          halted = 1'b1;
          state_n = take_irq ? INT_SAVE : HALT;
        end
        INT_SAVE: begin
          reg_out_en = 1'b1;
          reg_dst_sel = LINK_REG;
          reg_in_en = 1'b1;
          ie_n = 1'b0;
          state_n = INT_JUMP;
        end
        INT_JUMP: begin
          ctl_out_en = 1'b1;
          reg_in_en = 1'b1;
          irq_ack = 1'b1;
          state_n = FETCH_ADDR;
        end
        default: state_n = FETCH_ADDR;
      endcase
    end
    out = !ctl_out_en ? '0
        : state == INT_JUMP ? WIDTH'(IRQ_VECTOR)
        : op == 4'd12 || op == 4'd13 ? WIDTH'(inst[11:0]) : WIDTH'(inst[7:0]);
  end
endmodule

// File: tb/tb_ctl_sequencer.sv
// tb_ctl_sequencer: table-driven instruction vectors plus hand-built multi-cycle sequences, scoreboarded per cycle.
module tb_ctl_sequencer;
  typedef logic [21:0] cw_t;
  typedef struct { cw_t cw; logic [15:0] o; string tag; } exp_t;
  typedef struct { string tag; logic [15:0] i; logic [3:0] f; int n; cw_t s0, s1, s2; logic [15:0] o0, o1, o2; } vec_t;
  localparam cw_t AOE = cw_t'(1) << 17, AR = cw_t'(1) << 16, MA = cw_t'(1) << 15, MI = cw_t'(1) << 14;
  localparam cw_t MO = cw_t'(1) << 13, RI = cw_t'(1) << 6, RO = cw_t'(1) << 5, PCI = cw_t'(1) << 4;
  localparam cw_t CO = cw_t'(1) << 3, DSP = cw_t'(1) << 2, ACK = cw_t'(1) << 1, HLT = cw_t'(1);
  localparam cw_t FA = RO | MA, FD = MO | PCI, IS = RO | (cw_t'(1) << 7) | RI, IJ = CO | RI | ACK;
  logic clk = 1'b0, rst, mem_ready, irq;
  logic [15:0] in, out;
  logic [3:0] flags, alu_opcode;
  logic alu_out_en, alu_ar_flag, mem_addr_en, mem_in_en, mem_out_en;
  logic [2:0] reg_src_sel, reg_dst_sel;
  logic reg_in_en, reg_out_en, reg_pc_inc, ctl_out_en, dsp_in_en, irq_ack, halted;
  cw_t cw;
  exp_t q[$];
  exp_t cur;
  vec_t tv[20];
  vec_t set_v, clr_v;
  int checks = 0, failures = 0;
  ctl_sequencer dut (
    .clk(clk), .rst(rst), .in(in), .flags(flags), .mem_ready(mem_ready), .irq(irq),
    .alu_opcode(alu_opcode), .alu_out_en(alu_out_en), .alu_ar_flag(alu_ar_flag),
    .mem_addr_en(mem_addr_en), .mem_in_en(mem_in_en), .mem_out_en(mem_out_en),
    .reg_src_sel(reg_src_sel), .reg_dst_sel(reg_dst_sel), .reg_in_en(reg_in_en),
    .reg_out_en(reg_out_en), .reg_pc_inc(reg_pc_inc), .ctl_out_en(ctl_out_en),
    .dsp_in_en(dsp_in_en), .out(out), .irq_ack(irq_ack), .halted(halted)
  );
  always #5 clk = ~clk;
  assign cw = {alu_opcode, alu_out_en, alu_ar_flag, mem_addr_en, mem_in_en, mem_out_en,
               reg_src_sel, reg_dst_sel, reg_in_en, reg_out_en, reg_pc_inc, ctl_out_en,
               dsp_in_en, irq_ack, halted};
  function automatic cw_t aop(input logic [3:0] v); return cw_t'(v) << 18; endfunction
  function automatic cw_t rs(input logic [2:0] v); return cw_t'(v) << 10; endfunction
  function automatic cw_t rd(input logic [2:0] v); return cw_t'(v) << 7; endfunction
  task automatic check(input string tag, input logic [37:0] act, input logic [37:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic void push(input cw_t c, input logic [15:0] o, input string t);
    exp_t x;
    x.cw = c;
    x.o = o;
    x.tag = t;
    q.push_back(x);
  endfunction
  always @(negedge clk) begin
    if (q.size() != 0) begin
      cur = q.pop_front();
      check(cur.tag, {cw, out}, {cur.cw, cur.o});
    end
  end
  task automatic run(input string tag, input logic [15:0] i, input logic [3:0] f, input int n,
                     input logic [15:0] lo, input bit fa);
    in = i;
    flags = f;
    for (int k = 0; k < n; k++) begin
      mem_ready = !lo[k];
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    if (fa) check({tag, ".len"}, 38'({q.size() == 0, mem_addr_en, reg_out_en}), 38'(3'b111));
  endtask
  task automatic do_vec(input vec_t v);
    push(FA, 16'h0, {v.tag, ".fa"});
    push(FD, 16'h0, {v.tag, ".fd"});
    if (v.n > 2) push(v.s0, v.o0, {v.tag, ".e0"});
    if (v.n > 3) push(v.s1, v.o1, {v.tag, ".e1"});
    if (v.n > 4) push(v.s2, v.o2, {v.tag, ".e2"});
    run(v.tag, v.i, v.f, v.n, 16'h0, 1'b1);
  endtask
  initial begin
    rst = 1'b1; in = 16'h0; flags = 4'h0; mem_ready = 1'b1; irq = 1'b0;
    tv[0]  = '{"nop", 16'h0000, 4'h0, 3, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{"ld_reg", 16'h1650, 4'h0, 3, rs(3'd5) | RO | rd(3'd3) | RI, 0, 0, 0, 0, 0};
    tv[2]  = '{"ld_imm", 16'h19A7, 4'h0, 3, CO | rd(3'd4) | RI, 0, 0, 16'h00A7, 0, 0};
    tv[3]  = '{"ld_ind", 16'h14E0, 4'h0, 4, rs(3'd6) | RO | MA, MO | rd(3'd2) | RI, 0, 0, 0, 0};
    tv[4]  = '{"st", 16'h2A30, 4'h0, 4, rs(3'd3) | RO | MA, rs(3'd5) | RO | MI, 0, 0, 0, 0};
    tv[5]  = '{"add_reg", 16'h3220, 4'h0, 3, aop(4'd3) | AOE | rs(3'd2) | rd(3'd1) | RI, 0, 0, 0, 0, 0};
    tv[6]  = '{"add_imm", 16'h3505, 4'h0, 4, CO | rd(3'd7) | RI,
               aop(4'd3) | AOE | rs(3'd7) | rd(3'd2) | RI, 0, 16'h0005, 0, 0};
    tv[7]  = '{"alu_ind", 16'h5CC0, 4'h0, 5, rs(3'd4) | RO | MA, MO | rd(3'd7) | RI,
               aop(4'd5) | AOE | rs(3'd7) | rd(3'd6) | RI, 0, 0, 0};
    tv[8]  = '{"cmp_ind", 16'hE690, 4'h0, 5, rs(3'd1) | RO | MA, MO | rd(3'd7) | RI,
               aop(4'd4) | AOE | rs(3'd7) | rd(3'd3), 0, 0, 0};
    tv[9]  = '{"shift_ar", 16'hA530, 4'h0, 3, aop(4'd10) | AOE | AR | rs(3'd3) | rd(3'd2) | RI, 0, 0, 0, 0, 0};
    tv[10] = '{"jmp", 16'hC123, 4'h0, 3, CO | RI, 0, 0, 16'h0123, 0, 0};
    tv[11] = '{"jsr", 16'hD456, 4'h0, 4, RO | rd(3'd1) | RI, CO | RI, 0, 0, 16'h0456, 0};
    tv[12] = '{"br_z_taken", 16'hF030, 4'b1000, 3, rs(3'd3) | RO | RI, 0, 0, 0, 0, 0};
    tv[13] = '{"br_z_not", 16'hF030, 4'b0000, 3, 0, 0, 0, 0, 0, 0};
    tv[14] = '{"br_imm_taken", 16'hF742, 4'b0000, 3, CO | RI, 0, 0, 16'h0042, 0, 0};
    tv[15] = '{"br_imm_not", 16'hF742, 4'b0100, 3, 0, 0, 0, 0, 0, 0};
    tv[16] = '{"br_ind_v", 16'hFCA0, 4'b0001, 4, rs(3'd2) | RO | MA, MO | RI, 0, 0, 0, 0};
    tv[17] = '{"out_reg", 16'h0250, 4'h0, 3, rs(3'd5) | RO | DSP, 0, 0, 0, 0, 0};
    tv[18] = '{"out_ind", 16'h02D0, 4'h0, 4, rs(3'd5) | RO | MA, MO | DSP, 0, 0, 0, 0};
    tv[19] = '{"sys_unknown", 16'h0600, 4'h0, 3, 0, 0, 0, 0, 0, 0};
    set_v = '{"set", 16'h0300, 4'h0, 3, 0, 0, 0, 0, 0, 0};
    clr_v = '{"clr", 16'h0400, 4'h0, 3, 0, 0, 0, 0, 0, 0};
    push(0, 16'h0, "rst_outputs");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    foreach (tv[j]) do_vec(tv[j]);
    push(FA, 16'h0, "wait_ld.fa"); push(FD, 16'h0, "wait_ld.fd");
    push(rs(3'd6) | RO | MA, 16'h0, "wait_ld.e0");
    for (int k = 0; k < 3; k++) push(MO | rd(3'd2) | RI, 16'h0, "wait_ld.e1");
    run("wait_ld", 16'h14E0, 4'h0, 6, 16'b11000, 1'b1);
    push(FA, 16'h0, "wait_fd.fa"); push(MO, 16'h0, "wait_fd.stall");
    push(FD, 16'h0, "wait_fd.fd"); push(0, 16'h0, "wait_fd.e0");
    run("wait_fd", 16'h0000, 4'h0, 4, 16'b10, 1'b1);
    do_vec(set_v);
    irq = 1'b1;
    push(0, 16'h0, "irq.take"); push(IS, 16'h0, "irq.save"); push(IJ, 16'h0010, "irq.jump");
    run("irq", 16'h0000, 4'h0, 3, 16'h0, 1'b1);
    do_vec(tv[0]);
    push(FA, 16'h0, "set_irq.fa"); push(FD, 16'h0, "set_irq.fd"); push(0, 16'h0, "set_irq.e0");
    push(0, 16'h0, "set_irq.take"); push(IS, 16'h0, "set_irq.save"); push(IJ, 16'h0010, "set_irq.jump");
    run("set_irq", 16'h0300, 4'h0, 6, 16'h0, 1'b1);
    irq = 1'b0;
    do_vec(set_v);
    do_vec(clr_v);
    irq = 1'b1;
    do_vec(tv[0]);
    irq = 1'b0;
    push(FA, 16'h0, "hlt.fa"); push(FD, 16'h0, "hlt.fd"); push(0, 16'h0, "hlt.e0");
    for (int k = 0; k < 10; k++) push(HLT, 16'h0, "hlt.halted");
    run("hlt", 16'h0F00, 4'h0, 13, 16'h0, 1'b0);
    irq = 1'b1;
    for (int k = 0; k < 5; k++) push(HLT, 16'h0, "hlt.irq_masked");
    run("hlt_masked", 16'h0F00, 4'h0, 5, 16'h0, 1'b0);
    irq = 1'b0;
    rst = 1'b1;
    push(0, 16'h0, "hlt.rst_outputs");
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_vec(set_v);
    push(FA, 16'h0, "wake.fa"); push(FD, 16'h0, "wake.fd"); push(0, 16'h0, "wake.e0");
    push(HLT, 16'h0, "wake.halted"); push(HLT, 16'h0, "wake.halted");
    run("wake_hlt", 16'h0F00, 4'h0, 5, 16'h0, 1'b0);
    irq = 1'b1;
    push(HLT, 16'h0, "wake.irq"); push(IS, 16'h0, "wake.save"); push(IJ, 16'h0010, "wake.jump");
    run("wake", 16'h0F00, 4'h0, 3, 16'h0, 1'b1);
    irq = 1'b0;
    push(FA, 16'h0, "abort.fa"); push(FD, 16'h0, "abort.fd"); push(rs(3'd6) | RO | MA, 16'h0, "abort.e0");
    run("abort", 16'h14E0, 4'h0, 3, 16'h0, 1'b0);
    rst = 1'b1;
    push(0, 16'h0, "abort.rst_outputs");
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_vec(tv[0]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
